// File: rtl/sd_read_arbiter.sv
// sd_read_arbiter
//   Round-robin scheduler sharing one SPI-mode SD command engine between
//   NUM_REQ block-read requesters. Waits for card init, builds the CMD17
//   argument for the detected card type, runs one engine transaction at a
//   time and routes the returned bytes plus completion status back to the
//   granted requester.
//
// Ports
//   clk, rst_n        system clock, synchronous active-low reset
//   req_valid/lba     per-requester read request and block address (32b each)
//   req_ready         one-hot acceptance pulse
//   card_ready, sdhc  init complete; 1 = block addressing, 0 = byte addressing
//   eng_start/cmd/arg command-engine launch (cmd 17, arg held until done)
//   eng_busy/done/err engine status; err valid with done
//   eng_data_valid/data  read byte stream from the engine
//   rsp_data_valid/data  registered byte stream to the granted requester
//   rsp_done/err      one-hot completion pulse and status
//   grant_id          current/last granted requester
module sd_read_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [32*NUM_REQ-1:0]      req_lba,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       card_ready,
  input  logic                       sdhc,
  output logic                       eng_start,
  output logic [5:0]                 eng_cmd,
  output logic [31:0]                eng_arg,
  input  logic                       eng_busy,
  input  logic                       eng_done,
  input  logic                       eng_err,
  input  logic                       eng_data_valid,
  input  logic [7:0]                 eng_data,
  output logic [NUM_REQ-1:0]         rsp_data_valid,
  output logic [7:0]                 rsp_data,
  output logic [NUM_REQ-1:0]         rsp_done,
  output logic [NUM_REQ-1:0]         rsp_err,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int         IDW   = $clog2(NUM_REQ);
  localparam logic [5:0] CMD17 = 6'd17;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_DONE
  } state_t;

  state_t          state;
  logic [IDW-1:0]  last_grant;
  logic [31:0]     lba_q;
  logic [9:0]      byte_cnt;
  logic [31:0]     wdog;
  logic            err_q;

  // Arbitration: prefer the lowest set index above last_grant, else wrap
  // to the lowest set index at or below it.
  logic            hi_found, lo_found, pick_found;
  logic [IDW-1:0]  hi_id, lo_id, pick_id;
  logic [31:0]     pick_lba;

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned and a latch can never be inferred.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    pick_lba = '0;
    // Descending scan: the last hit written is the smallest index.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (IDW'(i) > last_grant) begin
          hi_found = 1'b1;
          hi_id    = IDW'(i);
        end else begin
          lo_found = 1'b1;
          lo_id    = IDW'(i);
        end
      end
    end
    pick_found = hi_found | lo_found;
    pick_id    = hi_found ? hi_id : lo_id;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == pick_id) pick_lba = req_lba[32*i +: 32];
    end
  end

  // SDSC cards take a byte address; only 23 LBA bits fit after the shift.
  logic        out_of_range;
  logic [31:0] cmd_arg;
  assign out_of_range = !sdhc && (lba_q[31:23] != 9'd0);
  assign cmd_arg      = sdhc ? lba_q : {lba_q[22:0], 9'd0};

  // Byte count including this cycle's byte, saturating so long bursts
  // cannot wrap back to 512 and look like a clean block.
  logic [9:0] cnt_next;
  assign cnt_next = (eng_data_valid && byte_cnt != 10'h3FF) ? byte_cnt + 10'd1
                                                            : byte_cnt;

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      last_grant     <= IDW'(NUM_REQ - 1);
      lba_q          <= '0;
      byte_cnt       <= '0;
      wdog           <= '0;
      err_q          <= 1'b0;
      req_ready      <= '0;
      eng_start      <= 1'b0;
      eng_cmd        <= '0;
      eng_arg        <= '0;
      rsp_data_valid <= '0;
      rsp_data       <= '0;
      rsp_done       <= '0;
      rsp_err        <= '0;
      grant_id       <= '0;
    end else begin
      // Pulse outputs default low; states raise them for one cycle.
      req_ready      <= '0;
      eng_start      <= 1'b0;
      rsp_data_valid <= '0;
      rsp_done       <= '0;
      rsp_err        <= '0;

      case (state)
        S_IDLE: begin
          if (card_ready && !eng_busy && pick_found) begin
            grant_id   <= pick_id;
            last_grant <= pick_id;
            lba_q      <= pick_lba;
            state      <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          req_ready[grant_id] <= 1'b1;
          if (out_of_range) begin
            err_q <= 1'b1;
            state <= S_DONE;
          end else begin
            eng_start <= 1'b1;
            eng_cmd   <= CMD17;
            eng_arg   <= cmd_arg;
            byte_cnt  <= '0;
            wdog      <= '0;
            err_q     <= 1'b0;
            state     <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (eng_data_valid) begin
            rsp_data_valid[grant_id] <= 1'b1;
            rsp_data                 <= eng_data;
          end
          byte_cnt <= cnt_next;
          wdog     <= wdog + 32'd1;
          if (eng_done) begin
            err_q <= eng_err || (cnt_next != 10'd512);
            state <= S_DONE;
          end else if (wdog == 32'(TIMEOUT_CYCLES - 1)) begin
            err_q <= 1'b1;
            state <= S_DRAIN;
          end
        end

        // Engine is abandoned: swallow its bytes until it lets go.
        S_DRAIN: begin
          if (eng_done || !eng_busy) state <= S_DONE;
        end

        S_DONE: begin
          rsp_done[grant_id] <= 1'b1;
          rsp_err[grant_id]  <= err_q;
          state              <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_read_arbiter.sv
// Testbench for sd_read_arbiter: table of single-read vectors followed by
// hand-written sequences for card gating, reset mid-transaction,
// round-robin and watchdog/drain behaviour. A second instance with a short
// watchdog runs in lockstep on the same stimulus for the timeout case.
module tb_sd_read_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [63:0] req_lba;
  logic        card_ready, sdhc;
  logic        eng_busy, eng_done, eng_err, eng_data_valid;
  logic [7:0]  eng_data;

  logic [1:0]  req_ready, rsp_data_valid, rsp_done, rsp_err;
  logic        eng_start;
  logic [5:0]  eng_cmd;
  logic [31:0] eng_arg;
  logic [7:0]  rsp_data;
  logic [0:0]  grant_id;

  logic [1:0]  to_req_ready, to_rsp_data_valid, to_rsp_done, to_rsp_err;
  logic        to_eng_start;
  logic [5:0]  to_eng_cmd;
  logic [31:0] to_eng_arg;
  logic [7:0]  to_rsp_data;
  logic [0:0]  to_grant_id;

  always #5 clk = ~clk;

  sd_read_arbiter #(.NUM_REQ(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_lba(req_lba),
    .req_ready(req_ready), .card_ready(card_ready), .sdhc(sdhc),
    .eng_start(eng_start), .eng_cmd(eng_cmd), .eng_arg(eng_arg),
    .eng_busy(eng_busy), .eng_done(eng_done), .eng_err(eng_err),
    .eng_data_valid(eng_data_valid), .eng_data(eng_data),
    .rsp_data_valid(rsp_data_valid), .rsp_data(rsp_data),
    .rsp_done(rsp_done), .rsp_err(rsp_err), .grant_id(grant_id)
  );

  sd_read_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(100)) dut_to (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_lba(req_lba),
    .req_ready(to_req_ready), .card_ready(card_ready), .sdhc(sdhc),
    .eng_start(to_eng_start), .eng_cmd(to_eng_cmd), .eng_arg(to_eng_arg),
    .eng_busy(eng_busy), .eng_done(eng_done), .eng_err(eng_err),
    .eng_data_valid(eng_data_valid), .eng_data(eng_data),
    .rsp_data_valid(to_rsp_data_valid), .rsp_data(to_rsp_data),
    .rsp_done(to_rsp_done), .rsp_err(to_rsp_err), .grant_id(to_grant_id)
  );

  int total = 0;
  int bad   = 0;
  int data_bad = 0, onehot_bad = 0;
  int start_cnt = 0, rr_cnt = 0, to_done_cnt = 0;
  int fwd_cnt[2];
  int to_fwd_cnt[2];

  typedef struct {
    int          who;
    logic [31:0] lba;
    logic        sdhc;
    int          nbytes;
    logic        eerr;
    logic [31:0] exp_arg;
    logic        oor;
    logic        exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and record what the DUTs produced.
  task automatic step();
    logic [7:0] sent_data;
    logic       sent_dv;
    sent_data = eng_data;
    sent_dv   = eng_data_valid;
    @(negedge clk);
    if (rsp_data_valid != 2'b00 && (!sent_dv || rsp_data !== sent_data))
      data_bad++;
    if ($countones(req_ready) > 1 || $countones(rsp_done) > 1 ||
        $countones(rsp_data_valid) > 1)
      onehot_bad++;
    if (eng_start) start_cnt++;
    if (req_ready != 2'b00) rr_cnt++;
    if (to_rsp_done != 2'b00) to_done_cnt++;
    for (int i = 0; i < 2; i++) begin
      fwd_cnt[i]    += int'(rsp_data_valid[i]);
      to_fwd_cnt[i] += int'(to_rsp_data_valid[i]);
    end
  endtask

  task automatic set_req(input int who, input logic [31:0] lba);
    if (who == 0) begin
      req_lba[31:0] = lba;
      req_valid[0]  = 1'b1;
    end else begin
      req_lba[63:32] = lba;
      req_valid[1]   = 1'b1;
    end
  endtask

  // One full transaction from a requester already presenting req_valid in
  // IDLE: acceptance, engine play-back of nbytes, completion.
  task automatic run_txn(input string name, input int id,
                         input logic [31:0] arg, input logic oor,
                         input int nbytes, input logic err_in,
                         input logic err_exp, input logic hold);
    int         n, fwd0, st0;
    logic [1:0] oh;
    oh   = (id == 0) ? 2'b01 : 2'b10;
    fwd0 = fwd_cnt[id];
    st0  = start_cnt;
    n    = 0;
    while (req_ready == 2'b00 && n < 10) begin
      step();
      n++;
    end
    check({name, "_accept_lat"}, n, 2);
    check({name, "_req_ready"}, req_ready, oh);
    check({name, "_grant_id"}, grant_id, id);
    if (!hold) begin
      if (id == 0) req_valid[0] = 1'b0;
      else         req_valid[1] = 1'b0;
    end
    if (!oor) begin
      check({name, "_eng_start"}, eng_start, 1);
      check({name, "_eng_cmd"}, eng_cmd, 17);
      check({name, "_eng_arg"}, eng_arg, arg);
      eng_busy = 1'b1;
      for (int b = 0; b < nbytes; b++) begin
        eng_data_valid = 1'b1;
        eng_data       = 8'(b) ^ 8'h5A;
        eng_done       = (b == nbytes - 1);
        eng_err        = err_in;
        step();
      end
    end else begin
      check({name, "_no_start"}, eng_start, 0);
    end
    eng_busy       = 1'b0;
    eng_data_valid = 1'b0;
    eng_done       = 1'b0;
    eng_err        = 1'b0;
    n = 0;
    while (rsp_done == 2'b00 && n < 10) begin
      step();
      n++;
    end
    check({name, "_done_lat"}, n, 1);
    check({name, "_rsp_done"}, rsp_done, oh);
    check({name, "_rsp_err"}, rsp_err, err_exp ? oh : 2'b00);
    check({name, "_starts"}, start_cnt - st0, oor ? 0 : 1);
    if (!oor) check({name, "_fwd_bytes"}, fwd_cnt[id] - fwd0, nbytes);
  endtask

  initial begin
    int n, rr0, st0, tf0, mf0, td0;

    vecs[0] = '{0, 32'h0000_0010, 1'b1, 512,  1'b0, 32'h0000_0010, 1'b0, 1'b0};
    vecs[1] = '{1, 32'h0000_1234, 1'b1, 512,  1'b0, 32'h0000_1234, 1'b0, 1'b0};
    vecs[2] = '{1, 32'h0000_0003, 1'b0, 512,  1'b0, 32'h0000_0600, 1'b0, 1'b0};
    vecs[3] = '{0, 32'h0080_0000, 1'b0, 0,    1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[4] = '{0, 32'h007F_FFFF, 1'b0, 512,  1'b0, 32'hFFFF_FE00, 1'b0, 1'b0};
    vecs[5] = '{1, 32'h0000_0005, 1'b1, 500,  1'b0, 32'h0000_0005, 1'b0, 1'b1};
    vecs[6] = '{0, 32'h0000_0006, 1'b1, 512,  1'b1, 32'h0000_0006, 1'b0, 1'b1};
    vecs[7] = '{1, 32'h0080_0000, 1'b1, 1536, 1'b0, 32'h0080_0000, 1'b0, 1'b1};
    vecs[8] = '{0, 32'hFFFF_FFFF, 1'b1, 513,  1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1};

    for (int i = 0; i < 2; i++) begin
      fwd_cnt[i]    = 0;
      to_fwd_cnt[i] = 0;
    end
    rst_n = 1'b0;  req_valid = 2'b00;  req_lba = '0;
    card_ready = 1'b1;  sdhc = 1'b1;
    eng_busy = 1'b0;  eng_done = 1'b0;  eng_err = 1'b0;
    eng_data_valid = 1'b0;  eng_data = 8'h00;

    repeat (3) step();
    check("reset_outputs", {req_ready, eng_start, eng_cmd, eng_arg,
          rsp_data_valid, rsp_data, rsp_done, rsp_err, grant_id}, 0);
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 9; v++) begin
      sdhc = vecs[v].sdhc;
      set_req(vecs[v].who, vecs[v].lba);
      run_txn($sformatf("vec%0d", v), vecs[v].who, vecs[v].exp_arg,
              vecs[v].oor, vecs[v].nbytes, vecs[v].eerr, vecs[v].exp_err,
              1'b0);
    end

    // No grant while the card is still initialising.
    sdhc = 1'b1;
    card_ready = 1'b0;
    set_req(0, 32'h0000_0042);
    rr0 = rr_cnt;
    st0 = start_cnt;
    repeat (20) step();
    check("card_gate_ready", rr_cnt - rr0, 0);
    check("card_gate_start", start_cnt - st0, 0);
    card_ready = 1'b1;
    run_txn("card_up", 0, 32'h0000_0042, 1'b0, 512, 1'b0, 1'b0, 1'b0);

    // Reset while requester 1 is in WAIT; both keep requesting.
    set_req(0, 32'h0000_00A0);
    set_req(1, 32'h0000_00B1);
    n = 0;
    while (!eng_start && n < 10) begin
      step();
      n++;
    end
    check("rst_pre_grant", grant_id, 1);
    check("rst_pre_arg", eng_arg, 32'h0000_00B1);
    eng_busy = 1'b1;
    for (int b = 0; b < 5; b++) begin
      eng_data_valid = 1'b1;
      eng_data       = 8'(b);
      step();
    end
    rst_n = 1'b0;
    eng_busy = 1'b0;
    eng_data_valid = 1'b0;
    step();
    check("rst_mid_outputs", {req_ready, eng_start, eng_cmd, eng_arg,
          rsp_data_valid, rsp_data, rsp_done, rsp_err, grant_id}, 0);
    rst_n = 1'b1;

    // Round-robin with both requesters held: 0,1,0,1.
    for (int k = 0; k < 4; k++) begin
      run_txn($sformatf("rr%0d", k), k % 2,
              (k % 2 == 0) ? 32'h0000_00A0 : 32'h0000_00B1,
              1'b0, 512, 1'b0, 1'b0, 1'b1);
    end
    req_valid = 2'b00;
    step();

    // Watchdog: engine streams 300 bytes while busy, then finishes.
    set_req(0, 32'h0000_0077);
    n = 0;
    while (!eng_start && n < 10) begin
      step();
      n++;
    end
    check("to_start_lat", n, 2);
    check("to_start_arg", to_eng_arg, 32'h0000_0077);
    req_valid = 2'b00;
    tf0 = to_fwd_cnt[0];
    mf0 = fwd_cnt[0];
    td0 = to_done_cnt;
    eng_busy = 1'b1;
    for (int b = 0; b < 300; b++) begin
      eng_data_valid = 1'b1;
      eng_data       = 8'(b) ^ 8'h5A;
      step();
    end
    check("to_no_early_done", to_done_cnt - td0, 0);
    eng_busy = 1'b0;
    eng_data_valid = 1'b0;
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    n = 0;
    while (to_rsp_done == 2'b00 && n < 10) begin
      step();
      n++;
    end
    check("to_done_lat", n, 1);
    check("to_rsp_done", to_rsp_done, 2'b01);
    check("to_rsp_err", to_rsp_err, 2'b01);
    check("to_fwd_bytes", to_fwd_cnt[0] - tf0, 100);
    check("to_main_rsp_err", rsp_err, 2'b01);
    check("to_main_fwd_bytes", fwd_cnt[0] - mf0, 300);

    step();
    check("data_route", data_bad, 0);
    check("onehot", onehot_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
